// File: rtl/gpr_pkg.sv
// Shared types and helpers for the general-purpose register bank.
// The write-match search is sized to the largest supported port count and address width.
package gpr_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int MAX_NWR   = 2;
  localparam int MAX_AW    = 16;
  localparam int MIDX_W    = $clog2(MAX_NWR);

  typedef logic [$clog2(NREGS_DEF)-1:0] gpr_addr_t;

  typedef struct packed {
    logic                en;
    gpr_addr_t           addr;
    logic [XLEN_DEF-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic              hit;
    logic [MIDX_W-1:0] idx;
  } wr_match_t;

  // Later ports overwrite earlier ones, so the highest matching index wins.
  function automatic wr_match_t find_wr_match(
    input logic [MAX_NWR-1:0]             en,
    input logic [MAX_NWR-1:0][MAX_AW-1:0] addr,
    input logic [MAX_AW-1:0]              a
  );
    wr_match_t m;
    m = '0;
    for (int k = 0; k < MAX_NWR; k++) begin
      if (en[k] && (addr[k] == a)) begin
        m.hit = 1'b1;
        m.idx = MIDX_W'(k);
      end
    end
    return m;
  endfunction

  function automatic logic wr_hits(
    input logic [MAX_NWR-1:0]             en,
    input logic [MAX_NWR-1:0][MAX_AW-1:0] addr,
    input logic [MAX_AW-1:0]              a
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < MAX_NWR; k++) begin
      if (en[k] && (addr[k] == a)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/gpr_bank_if.sv
// Decode/writeback-facing bus of the register bank: read, write and allocate ports.
interface gpr_bank_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     alloc_en;
  logic [AW-1:0]            alloc_addr;
  logic                     alloc_ok;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, alloc_ok
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, alloc_ok
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits for pipelined issue: set by accepted allocations, cleared by writes.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  input  logic [NRD-1:0]       rd_wr_hit,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR-1:0][AW-1:0] wr_addr,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  input  logic                 alloc_wr_hit,
  output logic [NRD-1:0]       rd_busy,
  output logic                 alloc_ok
);
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             alloc_zero;

  always_comb begin
    alloc_zero = ZR && (alloc_addr == '0);
    alloc_ok   = alloc_en & (alloc_zero | !busy_q[alloc_addr] | alloc_wr_hit);

    // Clear first so an allocation in the same cycle leaves the register busy.
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) busy_d[wr_addr[k]] = 1'b0;
    end
    if (alloc_ok && !alloc_zero) busy_d[alloc_addr] = 1'b1;

    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = busy_q[rd_addr[i]] & !(BP && rd_wr_hit[i])
                 & !(ZR && (rd_addr[i] == '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/gpr_bank.sv
// Multi-port register bank with optional same-cycle write bypass and a busy scoreboard.
module gpr_bank
  import gpr_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  gpr_bank_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0]              mem_q [NREGS];
  logic [XLEN-1:0]              mem_d [NREGS];
  logic [MAX_NWR-1:0]           wr_en_x;
  logic [MAX_NWR-1:0][MAX_AW-1:0] wr_addr_x;
  logic [XLEN-1:0]              wr_data_x [MAX_NWR];
  wr_match_t                    rd_match [NRD];
  logic [NRD-1:0]               rd_wr_hit;
  logic                         alloc_wr_hit;

  // Widen the write ports to the fixed shape the shared match helpers expect.
  always_comb begin
    wr_en_x   = '0;
    wr_addr_x = '0;
    for (int k = 0; k < MAX_NWR; k++) wr_data_x[k] = '0;
    for (int k = 0; k < NWR; k++) begin
      wr_en_x[k]   = bus.wr_en[k];
      wr_addr_x[k] = MAX_AW'(bus.wr_addr[k]);
      wr_data_x[k] = bus.wr_data[k];
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NWR; k++) begin
      if (bus.wr_en[k] && !(ZR && (bus.wr_addr[k] == '0)))
        mem_d[bus.wr_addr[k]] = bus.wr_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    rd_wr_hit   = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_match[i]  = find_wr_match(wr_en_x, wr_addr_x, MAX_AW'(bus.rd_addr[i]));
      rd_wr_hit[i] = rd_match[i].hit;
      if (ZR && (bus.rd_addr[i] == '0))
        bus.rd_data[i] = '0;
      else if (BP && rd_match[i].hit)
        bus.rd_data[i] = wr_data_x[rd_match[i].idx];
      else
        bus.rd_data[i] = mem_q[bus.rd_addr[i]];
    end
  end

  assign alloc_wr_hit = wr_hits(wr_en_x, wr_addr_x, MAX_AW'(bus.alloc_addr));

  gpr_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr      (bus.rd_addr),
    .rd_wr_hit    (rd_wr_hit),
    .wr_en        (bus.wr_en),
    .wr_addr      (bus.wr_addr),
    .alloc_en     (bus.alloc_en),
    .alloc_addr   (bus.alloc_addr),
    .alloc_wr_hit (alloc_wr_hit),
    .rd_busy      (bus.rd_busy),
    .alloc_ok     (bus.alloc_ok)
  );

endmodule

// File: tb/tb_gpr_bank.sv
// Bench for gpr_bank: directed vector table, reset corner sequence, then random traffic
// against a register/busy array model; a second bank without bypass shares the stimulus.
module tb_gpr_bank;

  logic clk;
  logic rst_n;

  gpr_bank_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();
  gpr_bank_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_nb ();

  assign bus_nb.rd_addr    = bus.rd_addr;
  assign bus_nb.wr_en      = bus.wr_en;
  assign bus_nb.wr_addr    = bus.wr_addr;
  assign bus_nb.wr_data    = bus.wr_data;
  assign bus_nb.alloc_en   = bus.alloc_en;
  assign bus_nb.alloc_addr = bus.alloc_addr;

  gpr_bank #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  gpr_bank #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural register contents and pending-write flags.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic bit any_write_to(input logic [4:0] a);
    bit h;
    h = 1'b0;
    for (int k = 0; k < 2; k++)
      if (bus.wr_en[k] && bus.wr_addr[k] == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit bp);
    logic [31:0] r;
    if (a == 5'd0) return 32'h0;
    r = m_mem[a];
    if (bp)
      for (int k = 0; k < 2; k++)
        if (bus.wr_en[k] && bus.wr_addr[k] == a) r = bus.wr_data[k];
    return r;
  endfunction

  function automatic logic exp_rbusy(input logic [4:0] a, input bit bp);
    if (a == 5'd0) return 1'b0;
    if (bp && any_write_to(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_aok();
    if (!bus.alloc_en) return 1'b0;
    return (bus.alloc_addr == 5'd0) || !m_busy[bus.alloc_addr] || any_write_to(bus.alloc_addr);
  endfunction

  task automatic model_edge();
    bit ok;
    ok = exp_aok();
    for (int k = 0; k < 2; k++) begin
      if (bus.wr_en[k]) begin
        if (bus.wr_addr[k] != 5'd0) m_mem[bus.wr_addr[k]] = bus.wr_data[k];
        m_busy[bus.wr_addr[k]] = 1'b0;
      end
    end
    if (ok && bus.alloc_addr != 5'd0) m_busy[bus.alloc_addr] = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        ae;
    logic [4:0]  aa;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_aok;
    logic [31:0] e_nb0;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 32'h0};
    vecs[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 5'd0, 5'd5, 1'b1, 5'd0, 32'h0, 32'hDEADBEEF, 2'b00, 1'b1, 32'h0};
    vecs[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0};
    vecs[4]  = '{2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0, 32'h0};
    vecs[5]  = '{2'b11, 5'd3, 32'h1, 5'd3, 32'h2, 5'd3, 5'd7, 1'b0, 5'd0, 32'h2, 32'hA5A5A5A5, 2'b00, 1'b0, 32'h0};
    vecs[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 32'h2, 32'h2, 2'b00, 1'b0, 32'h2};
    vecs[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd3, 1'b1, 5'd9, 32'h0, 32'h2, 2'b00, 1'b1, 32'h0};
    vecs[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h0, 32'h0, 2'b11, 1'b0, 32'h0};
    vecs[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd3, 1'b0, 5'd0, 32'h0, 32'h2, 2'b01, 1'b0, 32'h0};
    vecs[10] = '{2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h99, 32'h99, 2'b00, 1'b1, 32'h0};
    vecs[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 32'h99, 32'h99, 2'b11, 1'b0, 32'h99};
    vecs[12] = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h77, 5'd9, 5'd3, 1'b0, 5'd0, 32'h77, 32'h2, 2'b00, 1'b0, 32'h99};
    vecs[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 32'h77, 32'h0, 2'b00, 1'b0, 32'h77};
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    bus.rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Every register reads zero and idle after reset, on both ports.
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr[0] = 5'(a);
      bus.rd_addr[1] = 5'(31 - a);
      #1;
      chk("reset_rd0", bus.rd_data[0], 32'h0);
      chk("reset_rd1", bus.rd_data[1], 32'h0);
      chk("reset_busy", 32'(bus.rd_busy), 32'h0);
      chk("reset_nb_rd0", bus_nb.rd_data[0], 32'h0);
    end
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int v = 0; v < 14; v++) begin
      bus.wr_en      = vecs[v].we;
      bus.wr_addr[0] = vecs[v].wa0;
      bus.wr_data[0] = vecs[v].wd0;
      bus.wr_addr[1] = vecs[v].wa1;
      bus.wr_data[1] = vecs[v].wd1;
      bus.rd_addr[0] = vecs[v].ra0;
      bus.rd_addr[1] = vecs[v].ra1;
      bus.alloc_en   = vecs[v].ae;
      bus.alloc_addr = vecs[v].aa;
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", v), bus.rd_data[0], vecs[v].e_rd0);
      chk($sformatf("vec%0d_rd1", v), bus.rd_data[1], vecs[v].e_rd1);
      chk($sformatf("vec%0d_busy", v), 32'(bus.rd_busy), 32'(vecs[v].e_busy));
      chk($sformatf("vec%0d_aok", v), 32'(bus.alloc_ok), 32'(vecs[v].e_aok));
      chk($sformatf("vec%0d_nb_rd0", v), bus_nb.rd_data[0], vecs[v].e_nb0);
      @(posedge clk);
      model_edge();
      #1;
    end

    // Alloc and write x4 together, then reset in the middle of the next cycle.
    idle_inputs();
    bus.rd_addr[0] = 5'd4;
    bus.rd_addr[1] = 5'd4;
    bus.wr_en      = 2'b01;
    bus.wr_addr[0] = 5'd4;
    bus.wr_data[0] = 32'h55;
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'd4;
    @(posedge clk);
    model_edge();
    #1;
    idle_inputs();
    #1;
    chk("pre_rst_x4", bus.rd_data[0], 32'h55);
    chk("pre_rst_busy", 32'(bus.rd_busy[0]), 32'h1);
    #1;
    rst_n = 1'b0;
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'd4;
    model_reset();
    #1;
    chk("rst_x4", bus.rd_data[0], 32'h0);
    chk("rst_x4_nb", bus_nb.rd_data[0], 32'h0);
    chk("rst_busy", 32'(bus.rd_busy), 32'h0);
    chk("rst_aok", 32'(bus.alloc_ok), 32'h1);
    @(posedge clk);
    #1;
    chk("rst_hold_busy", 32'(bus.rd_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    bus.alloc_en = 1'b0;
    #1;
    chk("post_rst_busy", 32'(bus.rd_busy), 32'h3);
    chk("post_rst_x4", bus.rd_data[0], 32'h0);
    @(posedge clk);
    #1;

    // Random traffic against the model; narrow address range to force collisions.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        bus.wr_en[k]   = ($urandom_range(0, 2) == 0);
        bus.wr_addr[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        bus.wr_data[k] = $urandom;
        bus.rd_addr[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      end
      bus.alloc_en   = ($urandom_range(0, 1) == 0);
      bus.alloc_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rnd%0d_rd%0d", c, i), bus.rd_data[i], exp_rd(bus.rd_addr[i], 1'b1));
        chk($sformatf("rnd%0d_nb_rd%0d", c, i), bus_nb.rd_data[i], exp_rd(bus.rd_addr[i], 1'b0));
        chk($sformatf("rnd%0d_busy%0d", c, i), 32'(bus.rd_busy[i]), 32'(exp_rbusy(bus.rd_addr[i], 1'b1)));
        chk($sformatf("rnd%0d_nb_busy%0d", c, i), 32'(bus_nb.rd_busy[i]), 32'(exp_rbusy(bus.rd_addr[i], 1'b0)));
      end
      chk($sformatf("rnd%0d_aok", c), 32'(bus.alloc_ok), 32'(exp_aok()));
      chk($sformatf("rnd%0d_nb_aok", c), 32'(bus_nb.alloc_ok), 32'(exp_aok()));
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
